// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : IF/DM request ports and memory-side bus of mem_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: serves the CPU ports and drives the memory.
    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ack, if_rdata,
        output dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Environment side: CPU stages plus the memory model.
    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ack, if_rdata,
        input  dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Serialises IF and DM requests onto one single-ported,
//            fixed-latency memory; one-cycle ack per transaction.
//            Define ARB_RR_EN for round-robin arbitration on contention
//            (default: fixed DM priority).
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    localparam int c_cnt_w = $clog2(MEM_LAT + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam logic c_id_if = 1'b0;
    localparam logic c_id_dm = 1'b1;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_id;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;

    logic               w_accept;
    logic               w_grant_id;
    logic               w_last_beat;
    logic               w_capture;
    logic               w_mem_en;
    logic               w_if_ack;
    logic               w_dm_ack;

    assign w_accept    = (r_state == c_st_idle) && (bus.if_req || bus.dm_req);
    assign w_last_beat = (r_state == c_st_wait) && (r_cnt == c_cnt_w'(1));
    assign w_capture   = w_last_beat && !r_we;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    logic r_last_grant;

    // On contention the port that did not win last time takes the grant.
    always_comb begin
        w_grant_id = bus.dm_req ? c_id_dm : c_id_if;
        if (bus.dm_req && bus.if_req) begin
            w_grant_id = ~r_last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= c_id_if;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end
`else
    // DM serves the older instruction, so it always wins contention.
    assign w_grant_id = bus.dm_req ? c_id_dm : c_id_if;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue: begin
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                if (w_last_beat) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Reset masks the strobes so an aborted transaction
    // never produces an ack or a memory access.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_en = 1'b0;
        w_if_ack = 1'b0;
        w_dm_ack = 1'b0;
        if (!reset) begin
            case (r_state)
                c_st_issue: w_mem_en = 1'b1;
                c_st_resp: begin
                    w_if_ack = (r_id == c_id_if);
                    w_dm_ack = (r_id == c_id_dm);
                end
                default: begin
                    w_mem_en = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == c_st_issue) begin
            r_cnt <= c_cnt_w'(MEM_LAT);
        end else if ((r_state == c_st_wait) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Latched request: held on the memory bus until the next grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id    <= c_id_if;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_id <= w_grant_id;
            if (w_grant_id == c_id_dm) begin
                r_we    <= bus.dm_we;
                r_addr  <= bus.dm_addr;
                r_wdata <= bus.dm_wdata;
            end else begin
                r_we   <= 1'b0;
                r_addr <= bus.if_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data registers: updated only by a read to the same port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_capture) begin
            if (r_id == c_id_dm) begin
                r_dm_rdata <= bus.mem_rdata;
            end else begin
                r_if_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = w_if_ack;
    assign bus.dm_ack    = w_dm_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a
//            fixed-latency memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int MEM_LAT = 2;

    localparam logic [63:0] D_40  = 64'h0000_0000_F840_0001;
    localparam logic [63:0] D_48  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D_200 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model: 512 words indexed by addr[11:3]; read data appears
    // MEM_LAT cycles after the enable cycle, junk on every other cycle.
    logic [DATA_W-1:0] mem  [512];
    logic [DATA_W-1:0] pipe [MEM_LAT];

    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        if (bus.mem_en && !bus.mem_we) pipe[0] <= mem[bus.mem_addr[11:3]];
        else                           pipe[0] <= JUNK;
        if (reset) begin
            mem[8]  <= D_40;
            mem[9]  <= D_48;
            mem[64] <= D_200;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[11:3]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = pipe[MEM_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs n cycles starting at cycle 0 (called just after a rising edge).
    // Masks give the cycles where mem_en / if_ack / dm_ack must be high.
    // Unless hold is set, a port drops its request after its ack.
    task automatic run_txn(input string tag, input int n,
                           input logic [31:0] en_m, input logic [31:0] ifack_m,
                           input logic [31:0] dmack_m,
                           input logic [63:0] exp_if, input logic [63:0] exp_dm,
                           input bit hold);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d mem_en", tag, c), 64'(bus.mem_en), 64'(en_m[c]));
            chk($sformatf("%s c%0d if_ack", tag, c), 64'(bus.if_ack), 64'(ifack_m[c]));
            chk($sformatf("%s c%0d dm_ack", tag, c), 64'(bus.dm_ack), 64'(dmack_m[c]));
            if (en_m[c]) begin
                bit to_if;
                to_if = (c + 3 < 32) ? ifack_m[c+3] : 1'b0;
                chk($sformatf("%s c%0d mem_addr", tag, c), bus.mem_addr,
                    to_if ? bus.if_addr : bus.dm_addr);
                chk($sformatf("%s c%0d mem_we", tag, c), 64'(bus.mem_we),
                    to_if ? 64'd0 : 64'(bus.dm_we));
                if (!to_if && bus.dm_we)
                    chk($sformatf("%s c%0d mem_wdata", tag, c), bus.mem_wdata, bus.dm_wdata);
            end
            if (ifack_m[c]) chk($sformatf("%s c%0d if_rdata", tag, c), bus.if_rdata, exp_if);
            if (dmack_m[c]) chk($sformatf("%s c%0d dm_rdata", tag, c), bus.dm_rdata, exp_dm);
            @(posedge clk);
            #1;
            if (!hold && ifack_m[c]) bus.if_req = 1'b0;
            if (!hold && dmack_m[c]) bus.dm_req = 1'b0;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_en"}, 64'(bus.mem_en), 64'd0);
        chk({tag, " if_ack"}, 64'(bus.if_ack), 64'd0);
        chk({tag, " dm_ack"}, 64'(bus.dm_ack), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 64'h48;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 64'h200;
        bus.dm_wdata = '0;

        // Reset held two cycles with both requests pending.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk_quiet($sformatf("rst%0d", r));
            chk($sformatf("rst%0d mem_we", r), 64'(bus.mem_we), 64'd0);
            chk($sformatf("rst%0d mem_addr", r), bus.mem_addr, 64'd0);
            chk($sformatf("rst%0d mem_wdata", r), bus.mem_wdata, 64'd0);
            chk($sformatf("rst%0d if_rdata", r), bus.if_rdata, 64'd0);
            chk($sformatf("rst%0d dm_rdata", r), bus.dm_rdata, 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Contention out of reset: DM first, then the pending IF.
        run_txn("prio", 11, 32'h0000_0042, 32'h0000_0200, 32'h0000_0010, D_48, D_200, 1'b0);

        // Lone IF read.
        bus.if_addr = 64'h40;
        bus.if_req  = 1'b1;
        run_txn("if_rd", 6, 32'h2, 32'h10, 32'h0, D_40, 64'd0, 1'b0);

        // DM write leaves dm_rdata alone; read-back sees the written word.
        bus.dm_addr  = 64'h100;
        bus.dm_we    = 1'b1;
        bus.dm_wdata = 64'hDEAD;
        bus.dm_req   = 1'b1;
        run_txn("dm_wr", 6, 32'h2, 32'h0, 32'h10, 64'd0, D_200, 1'b0);
        bus.dm_we  = 1'b0;
        bus.dm_req = 1'b1;
        run_txn("dm_rb", 6, 32'h2, 32'h0, 32'h10, 64'd0, 64'hDEAD, 1'b0);

        // Reset pulsed in the first WAIT cycle of an IF read.
        bus.if_addr = 64'h48;
        bus.if_req  = 1'b1;
        @(negedge clk);
        chk("abort c0 mem_en", 64'(bus.mem_en), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort c1 mem_en", 64'(bus.mem_en), 64'd1);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk_quiet("abort c2");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 3; c < 6; c++) begin
            @(negedge clk);
            chk_quiet($sformatf("abort c%0d", c));
            chk($sformatf("abort c%0d if_rdata", c), bus.if_rdata, 64'd0);
            chk($sformatf("abort c%0d dm_rdata", c), bus.dm_rdata, 64'd0);
            @(posedge clk);
            #1;
        end
        bus.if_req = 1'b1;
        run_txn("retry", 6, 32'h2, 32'h10, 32'h0, D_48, 64'd0, 1'b0);

        // Both requests held for four transactions.
        bus.if_addr = 64'h40;
        bus.dm_addr = 64'h200;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
`ifdef ARB_RR_EN
        run_txn("contend", 20, 32'h0001_0842, 32'h0008_0200, 32'h0000_4010, D_40, D_200, 1'b1);
`else
        run_txn("contend", 20, 32'h0001_0842, 32'h0000_0000, 32'h0008_4210, D_40, D_200, 1'b1);
`endif
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk_quiet("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
